// File: rtl/tx_ft_pkg.sv
// Shared constants, FSM state type and packing/arithmetic helpers for the Tx
// fault-tolerant encoder.
package tx_ft_pkg;

  localparam int NUM_CH   = 8;
  localparam int CH_IDX_W = $clog2(NUM_CH);
  localparam int SAMPLE_W = 22;
  localparam int COMP_W   = 24;
  localparam int WORD_W   = 2 * COMP_W;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ACCUM   = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic logic [COMP_W-1:0] sext24(input logic signed [SAMPLE_W-1:0] x);
    return {{(COMP_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

  function automatic logic [WORD_W-1:0] pack_cplx(input logic signed [SAMPLE_W-1:0] re,
                                                  input logic signed [SAMPLE_W-1:0] im);
    return {sext24(im), sext24(re)};
  endfunction

  function automatic logic [COMP_W-1:0] wrap24(input logic [COMP_W-1:0] a,
                                               input logic [COMP_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/tx_ft_checksum_mac.sv
// Serial checksum accumulator: adds x and weight*x (per component, mod 2^24)
// for one packed complex sample per enabled cycle.
module tx_ft_checksum_mac
  import tx_ft_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_sample,
  input  logic [IDX_W-1:0]  i_weight,
  output logic [WORD_W-1:0] o_ck1,
  output logic [WORD_W-1:0] o_ck2
);

  logic [COMP_W-1:0] w_re, w_im, w_wre, w_wim;
  logic [COMP_W-1:0] r_ck1_re, r_ck1_im, r_ck2_re, r_ck2_im;

  assign w_re = i_sample[COMP_W-1:0];
  assign w_im = i_sample[WORD_W-1:COMP_W];

  // Shift-add multiply; dropping bits above 24 is the intended mod-2^24 arithmetic.
  always_comb begin
    w_wre = '0;
    w_wim = '0;
    for (int b = 0; b < IDX_W; b++) begin
      if (i_weight[b]) begin
        w_wre = wrap24(w_wre, w_re << b);
        w_wim = wrap24(w_wim, w_im << b);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ck1_re <= '0;
      r_ck1_im <= '0;
      r_ck2_re <= '0;
      r_ck2_im <= '0;
    end else if (i_clear) begin
      r_ck1_re <= '0;
      r_ck1_im <= '0;
      r_ck2_re <= '0;
      r_ck2_im <= '0;
    end else if (i_en) begin
      r_ck1_re <= wrap24(r_ck1_re, w_re);
      r_ck1_im <= wrap24(r_ck1_im, w_im);
      r_ck2_re <= wrap24(r_ck2_re, w_wre);
      r_ck2_im <= wrap24(r_ck2_im, w_wim);
    end
  end

  assign o_ck1 = {r_ck1_im, r_ck1_re};
  assign o_ck2 = {r_ck2_im, r_ck2_re};

endmodule

// File: rtl/tx_channelization_ft_encoder.sv
// Collects one sample per Tx channel, computes the two checksum channels serially
// and presents data + CK1/CK2 as one frame with a valid/ready handshake.
module tx_channelization_ft_encoder
  import tx_ft_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                       prj_clk,
  input  logic                       prj_rst,
  input  logic signed [SAMPLE_W-1:0] tx_in_real [NUM_CH],
  input  logic signed [SAMPLE_W-1:0] tx_in_imag [NUM_CH],
  input  logic [NUM_CH-1:0]          tx_in_tvalid,
  output logic [NUM_CH-1:0]          tx_in_tready,
  output logic [WORD_W-1:0]          extra_out_data [NUM_CH],
  output logic [WORD_W-1:0]          extra_out_ck1,
  output logic [WORD_W-1:0]          extra_out_ck2,
  output logic                       extra_out_tvalid,
  input  logic                       extra_out_tready,
  output logic                       frame_drop,
  output logic [15:0]                frame_count
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              r_state, w_state_next;
  logic [WORD_W-1:0]   r_slot [NUM_CH];
  logic [NUM_CH-1:0]   r_full, w_full_next, w_capture;
  logic [TIMER_W-1:0]  r_timer;
  logic [IDX_W-1:0]    r_idx;
  logic                r_drop;
  logic [15:0]         r_count;
  logic                w_timeout, w_mac_clear, w_mac_en;
  logic [WORD_W-1:0]   w_ck1, w_ck2;

  assign w_capture   = tx_in_tvalid & tx_in_tready;
  assign w_full_next = r_full | w_capture;
  assign w_timeout   = (r_state == COLLECT) && (r_timer == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    tx_in_tready = '0;
    case (r_state)
      COLLECT: begin
        if (!prj_rst) tx_in_tready = ~r_full;
        if (!w_timeout && (&w_full_next)) w_state_next = ACCUM;
      end
      // Index NUM_CH is a drain cycle letting the last MAC update settle.
      ACCUM:   if (r_idx == IDX_W'(NUM_CH)) w_state_next = OUTPUT;
      OUTPUT:  if (extra_out_tready) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge prj_clk or posedge prj_rst) begin
    if (prj_rst) r_state <= COLLECT;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge prj_clk or posedge prj_rst) begin
    if (prj_rst) begin
      r_full  <= '0;
      r_timer <= '0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
      r_count <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        COLLECT: begin
          r_idx <= '0;
          if (w_timeout) begin
            r_full  <= '0;
            r_timer <= '0;
            r_drop  <= 1'b1;
          end else begin
            r_full <= w_full_next;
            if (&w_full_next)      r_timer <= '0;
            else if (|w_full_next) r_timer <= r_timer + 1'b1;
          end
        end
        ACCUM:   r_idx <= r_idx + 1'b1;
        OUTPUT: begin
          if (extra_out_tready) begin
            r_full  <= '0;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    always_ff @(posedge prj_clk or posedge prj_rst) begin
      if (prj_rst)
        r_slot[gi] <= '0;
      else if (w_capture[gi] && !w_timeout)
        r_slot[gi] <= pack_cplx(tx_in_real[gi], tx_in_imag[gi]);
    end
    assign extra_out_data[gi] = (r_state == OUTPUT) ? r_slot[gi] : '0;
  end

  assign w_mac_clear = (r_state == COLLECT) && (w_state_next == ACCUM);
  assign w_mac_en    = (r_state == ACCUM) && !r_idx[IDX_W-1];

  tx_ft_checksum_mac u_mac (
    .i_clk    (prj_clk),
    .i_rst    (prj_rst),
    .i_clear  (w_mac_clear),
    .i_en     (w_mac_en),
    .i_sample (r_slot[r_idx[CH_IDX_W-1:0]]),
    .i_weight (r_idx + 1'b1),
    .o_ck1    (w_ck1),
    .o_ck2    (w_ck2)
  );

  assign extra_out_tvalid = (r_state == OUTPUT);
  assign extra_out_ck1    = (r_state == OUTPUT) ? w_ck1 : '0;
  assign extra_out_ck2    = (r_state == OUTPUT) ? w_ck2 : '0;
  assign frame_drop       = r_drop;
  assign frame_count      = r_count;

endmodule

// File: tb/tb_tx_channelization_ft_encoder.sv
// Bench for tx_channelization_ft_encoder: table vectors, hand-written corner
// sequences and randomized frames against an arithmetic checksum model.
module tb_tx_channelization_ft_encoder;

  localparam int N  = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [21:0] in_re [N];
  logic signed [21:0] in_im [N];
  logic [N-1:0]      in_valid, in_ready;
  logic [47:0]       out_data [N];
  logic [47:0]       ck1, ck2;
  logic              out_valid, out_ready, drop;
  logic [15:0]       fcount;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  int mre [N];
  int mim [N];

  always #5 clk = ~clk;

  tx_channelization_ft_encoder #(.TIMEOUT(TO)) dut (
    .prj_clk          (clk),
    .prj_rst          (rst),
    .tx_in_real       (in_re),
    .tx_in_imag       (in_im),
    .tx_in_tvalid     (in_valid),
    .tx_in_tready     (in_ready),
    .extra_out_data   (out_data),
    .extra_out_ck1    (ck1),
    .extra_out_ck2    (ck2),
    .extra_out_tvalid (out_valid),
    .extra_out_tready (out_ready),
    .frame_drop       (drop),
    .frame_count      (fcount)
  );

  typedef struct {
    logic [N-1:0][21:0] re;
    logic [N-1:0][21:0] im;
    logic [47:0]        ck1;
    logic [47:0]        ck2;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] word(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {i[23:0], r[23:0]};
  endfunction

  // Checksums straight from the definition: plain integer sums, then mod 2^24.
  function automatic logic [47:0] model_ck(input bit weighted);
    int sr, si, w;
    sr = 0;
    si = 0;
    for (int k = 0; k < N; k++) begin
      w  = weighted ? (k + 1) : 1;
      sr += w * mre[k];
      si += w * mim[k];
    end
    return word(sr, si);
  endfunction

  function automatic int rand22();
    logic [31:0] r;
    r = $urandom;
    return int'($signed(r[21:0]));
  endfunction

  task automatic drive_ch(input int k, input int re, input int im);
    in_re[k] = 22'(re);
    in_im[k] = 22'(im);
  endtask

  task automatic send_full();
    for (int k = 0; k < N; k++) drive_ch(k, mre[k], mim[k]);
    in_valid = '1;
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: tvalid still 0 after %0d cycles, required 1", name, lat);
    end
  endtask

  task automatic check_frame(input string name);
    for (int k = 0; k < N; k++) chk({name, "_data"}, out_data[k], word(mre[k], mim[k]));
    chk({name, "_ck1"}, ck1, model_ck(1'b0));
    chk({name, "_ck2"}, ck2, model_ck(1'b1));
  endtask

  task automatic accept(input string name);
    logic [7:0] all_ready;
    all_ready = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    chk({name, "_tvalid_drop"}, out_valid, 1'b0);
    chk({name, "_count"}, fcount, 16'(exp_count));
    chk({name, "_ready_back"}, in_ready, all_ready);
  endtask

  task automatic random_frame(input int id);
    logic [N-1:0] sent;
    logic [7:0]   exp_r;
    int cyc, lat, hold;
    for (int k = 0; k < N; k++) begin
      mre[k] = rand22();
      mim[k] = rand22();
    end
    sent = '0;
    cyc  = 0;
    out_ready = 1'b0;
    while (sent != '1) begin
      for (int k = 0; k < N; k++) begin
        if (!sent[k]) begin
          in_valid[k] = (cyc >= 6) || ($urandom_range(0, 1) == 1);
          drive_ch(k, mre[k], mim[k]);
        end else begin
          in_valid[k] = ($urandom_range(0, 3) == 0);
          drive_ch(k, rand22(), rand22());
        end
      end
      exp_r = ~sent;
      chk("rand_ready", in_ready, exp_r);
      @(posedge clk); #1;
      sent = sent | in_valid;
      cyc++;
    end
    in_valid = '0;
    wait_out("rand", lat);
    chk("rand_latency", 64'(lat), 64'd9);
    check_frame("rand");
    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end
    chk("rand_hold_valid", out_valid, 1'b1);
    accept("rand");
  endtask

  task automatic t_stagger();
    logic [N-1:0] filled;
    logic [7:0]   exp_r;
    int ch, lat;
    for (int k = 0; k < N; k++) begin
      mre[k] = 1000 * (k + 1) - 3;
      mim[k] = -77 * (k + 1);
    end
    filled = '0;
    for (int c = 0; c < N; c++) begin
      ch = 7 - c;
      in_valid = '0;
      in_valid[ch] = 1'b1;
      drive_ch(ch, mre[ch], mim[ch]);
      if (c == 5) begin
        in_valid[3] = 1'b1;
        drive_ch(3, 12345, -999);
        chk("stag_ready3_blocked", in_ready[3], 1'b0);
      end
      exp_r = ~filled;
      chk("stag_ready", in_ready, exp_r);
      @(posedge clk); #1;
      filled[ch] = 1'b1;
    end
    in_valid = '0;
    wait_out("stag", lat);
    chk("stag_latency", 64'(lat), 64'd9);
    check_frame("stag");
    accept("stag");
  endtask

  task automatic t_timeout();
    logic [7:0] exp_r;
    int first_drop, drops;
    logic saw_valid;
    for (int k = 0; k < N - 1; k++) drive_ch(k, rand22(), rand22());
    in_valid = 8'h7F;
    @(posedge clk); #1;
    in_valid = '0;
    exp_r = 8'h80;
    chk("to_ready_partial", in_ready, exp_r);
    first_drop = -1;
    drops = 0;
    saw_valid = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (drop) begin
        drops++;
        if (first_drop < 0) first_drop = n;
      end
      if (out_valid) saw_valid = 1'b1;
      if (n == 14) begin
        in_valid = 8'h80;
        drive_ch(7, 555, -555);
      end
      if (n == 15) in_valid = '0;
    end
    chk("to_drop_cycle", 64'(first_drop), 64'd15);
    chk("to_drop_pulses", 64'(drops), 64'd1);
    chk("to_no_tvalid", saw_valid, 1'b0);
    exp_r = 8'hFF;
    chk("to_slots_empty", in_ready, exp_r);
    chk("to_count", fcount, 16'(exp_count));
  endtask

  task automatic t_backpressure();
    logic [7:0] zero_r;
    int lat;
    zero_r = 8'h00;
    for (int k = 0; k < N; k++) begin
      mre[k] = rand22();
      mim[k] = rand22();
    end
    out_ready = 1'b0;
    send_full();
    wait_out("bp", lat);
    in_valid = '1;
    for (int k = 0; k < N; k++) drive_ch(k, 1, 1);
    for (int h = 0; h < 20; h++) begin
      chk("bp_tvalid", out_valid, 1'b1);
      chk("bp_ck1", ck1, model_ck(1'b0));
      chk("bp_ck2", ck2, model_ck(1'b1));
      chk("bp_data7", out_data[7], word(mre[7], mim[7]));
      chk("bp_in_ready", in_ready, zero_r);
      chk("bp_count", fcount, 16'(exp_count));
      @(posedge clk); #1;
    end
    in_valid = '0;
    check_frame("bp");
    accept("bp");
  endtask

  task automatic t_reset_mid();
    logic [7:0] zero_r, all_r;
    logic any_out;
    logic any_data;
    zero_r = 8'h00;
    all_r  = 8'hFF;
    for (int k = 0; k < N; k++) begin
      mre[k] = rand22();
      mim[k] = rand22();
    end
    out_ready = 1'b1;
    send_full();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    exp_count = 0;
    any_data = 1'b0;
    for (int k = 0; k < N; k++) if (out_data[k] != '0) any_data = 1'b1;
    chk("rst_mid_tvalid", out_valid, 1'b0);
    chk("rst_mid_ck1", ck1, 48'h0);
    chk("rst_mid_ck2", ck2, 48'h0);
    chk("rst_mid_data", any_data, 1'b0);
    chk("rst_mid_count", fcount, 16'h0);
    chk("rst_mid_drop", drop, 1'b0);
    chk("rst_mid_ready", in_ready, zero_r);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", in_ready, all_r);
    any_out = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid || drop) any_out = 1'b1;
    end
    chk("rst_mid_quiet", any_out, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_r;
    int lat;

    // All-at-once frames with hand-computed checksums.
    for (int k = 0; k < N; k++) begin
      vecs[0].re[k] = 22'(k + 1);
      vecs[0].im[k] = 22'(-(k + 1));
      vecs[1].re[k] = 22'h1FFFFF;
      vecs[1].im[k] = 22'h200000;
      vecs[2].re[k] = '0;
      vecs[2].im[k] = '0;
      vecs[3].re[k] = 22'h3FFFFF;
      vecs[3].im[k] = 22'd1;
      vecs[4].re[k] = '0;
      vecs[4].im[k] = '0;
    end
    vecs[4].re[7] = 22'd1000;
    vecs[4].im[7] = 22'h3FFFFD;
    vecs[0].ck1 = 48'hFFFFDC_000024;
    vecs[0].ck2 = 48'hFFFF34_0000CC;
    vecs[1].ck1 = 48'h000000_FFFFF8;
    vecs[1].ck2 = 48'h800000_7FFFDC;
    vecs[2].ck1 = 48'h0;
    vecs[2].ck2 = 48'h0;
    vecs[3].ck1 = 48'h000008_FFFFF8;
    vecs[3].ck2 = 48'h000024_FFFFDC;
    vecs[4].ck1 = 48'hFFFFFD_0003E8;
    vecs[4].ck2 = 48'hFFFFE8_001F40;

    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    for (int k = 0; k < N; k++) drive_ch(k, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_r = 8'h00;
    chk("reset_ready", in_ready, exp_r);
    chk("reset_tvalid", out_valid, 1'b0);
    chk("reset_count", fcount, 16'h0);
    chk("reset_drop", drop, 1'b0);
    chk("reset_ck1", ck1, 48'h0);
    rst = 1'b0;
    #1;
    exp_r = 8'hFF;
    chk("post_reset_ready", in_ready, exp_r);

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < N; k++) begin
        mre[k] = int'($signed(vecs[v].re[k]));
        mim[k] = int'($signed(vecs[v].im[k]));
      end
      send_full();
      wait_out("vec", lat);
      chk("vec_latency", 64'(lat), 64'd9);
      chk("vec_ck1_const", ck1, vecs[v].ck1);
      chk("vec_ck2_const", ck2, vecs[v].ck2);
      if (v == 0) chk("vec_data3_const", out_data[3], 48'hFFFFFC_000004);
      check_frame("vec");
      accept("vec");
    end

    t_stagger();
    t_timeout();
    random_frame(0);
    t_backpressure();
    t_reset_mid();
    for (int f = 1; f <= 25; f++) random_frame(f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
